// File: rtl/ospfb_seq_pkg.sv
// Shared types and helpers for the OSPFB control sequencer.
// Widths here are the defaults for a 32-point transform; the top derives its own from FFT_LEN.
package ospfb_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CONFIG   = 3'd1,
        WAIT_FFT = 3'd2,
        RUN      = 3'd3,
        HALT     = 3'd4
    } seq_state_e;

    localparam int FFT_LEN_DEF = 32;
    localparam int PHASE_W     = $clog2(FFT_LEN_DEF);
    localparam int DEC_W       = PHASE_W + 1;

    // A decimation factor is usable only if it selects 1..fft_len accept slots per frame.
    function automatic logic dec_fac_legal(input logic [31:0] req, input int unsigned fft_len);
        return (req != 32'd0) && (req <= fft_len);
    endfunction

endpackage

// File: rtl/ospfb_phase_ctr.sv
// Modulo-LEN decimator phase counter with synchronous load and a wrap strobe.
module ospfb_phase_ctr #(
    parameter int LEN      = 32,
    parameter int LOAD_VAL = 23,
    parameter int W        = $clog2(LEN)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    output logic [W-1:0] phase,
    output logic         wrap
);

    localparam logic [W-1:0] LAST  = W'(LEN - 1);
    localparam logic [W-1:0] START = W'(LOAD_VAL);

    assign wrap = en && (phase == LAST);

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            phase <= START;
        end else if (en) begin
            phase <= (phase == LAST) ? '0 : phase + W'(1);
        end
    end

endmodule

// File: rtl/ospfb_sequencer.sv
// OSPFB control sequencer: phase counter, upstream accept, FFT config/data framing, sticky errors.
// Optional OSPFB_SEQ_AUTO_RECOVER_EN: an FFT stall restarts from IDLE and bumps restart_cnt.
module ospfb_sequencer
    import ospfb_seq_pkg::*;
#(
    parameter int FFT_LEN     = 32,
    parameter int DEC_FAC_DEF = 24,
    parameter int SRT_PHA     = 23,
    parameter int TLAST_PHA   = 31,
    parameter int CONF_WID    = 8,
    parameter int CONF_DEF    = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [$clog2(FFT_LEN):0]   dec_fac,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    output logic                       vin,
    output logic                       fir_rst,
    output logic [$clog2(FFT_LEN)-1:0] phase,
    output logic                       cfg_tvalid,
    input  logic                       cfg_tready,
    output logic [CONF_WID-1:0]        cfg_tdata,
    output logic                       fft_tvalid,
    input  logic                       fft_tready,
    output logic                       fft_tlast,
    output logic [15:0]                frame_cnt,
    output logic                       err_underflow,
    output logic                       err_fft_stall,
    output logic                       err_dec_fac,
    output logic [2:0]                 state
`ifdef OSPFB_SEQ_AUTO_RECOVER_EN
    ,
    output logic [7:0]                 restart_cnt
`endif
);

    localparam int PH_W = $clog2(FFT_LEN);
    localparam int DF_W = PH_W + 1;

    seq_state_e      state_q, state_nxt;
    logic [DF_W-1:0] active_dec, active_dec_nxt;
    logic            pend, pend_nxt;
    logic [15:0]     frame_nxt;
    logic            uf_nxt, stall_nxt, df_nxt;
    logic            run_act, wrap, dec_legal, ctr_load;
`ifdef OSPFB_SEQ_AUTO_RECOVER_EN
    logic [7:0]      restart_nxt;
`endif

    assign run_act   = (state_q == RUN) && en;
    assign dec_legal = dec_fac_legal(32'(dec_fac), FFT_LEN);

    assign s_tready   = run_act && ({1'b0, phase} < active_dec);
    assign vin        = s_tready && s_tvalid;
    assign fir_rst    = (state_q != RUN);
    assign cfg_tvalid = (state_q == CONFIG);
    assign cfg_tdata  = CONF_WID'(CONF_DEF);
    assign fft_tvalid = (state_q == WAIT_FFT) || run_act;
    assign fft_tlast  = run_act && (phase == PH_W'(TLAST_PHA));
    assign state      = state_q;

    // Phase sits at SRT_PHA whenever the next cycle is not a RUN cycle, so RUN always opens there.
    assign ctr_load = (state_nxt != RUN);

    ospfb_phase_ctr #(
        .LEN      (FFT_LEN),
        .LOAD_VAL (SRT_PHA),
        .W        (PH_W)
    ) u_phase_ctr (
        .clk   (clk),
        .rst   (rst),
        .load  (ctr_load),
        .en    (run_act),
        .phase (phase),
        .wrap  (wrap)
    );

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_nxt      = state_q;
        active_dec_nxt = active_dec;
        pend_nxt       = pend;
        frame_nxt      = frame_cnt;
        uf_nxt         = err_underflow;
        stall_nxt      = err_fft_stall;
        df_nxt         = err_dec_fac;
`ifdef OSPFB_SEQ_AUTO_RECOVER_EN
        restart_nxt    = restart_cnt;
`endif

        case (state_q)
            IDLE: begin
                if (en && s_tvalid) begin
                    if (dec_legal) active_dec_nxt = dec_fac;
                    else           df_nxt         = 1'b1;
                    state_nxt = CONFIG;
                end
            end
            CONFIG: begin
                if (cfg_tready) state_nxt = WAIT_FFT;
            end
            WAIT_FFT: begin
                if (fft_tready) state_nxt = RUN;
            end
            RUN: begin
                if (en) begin
                    if (s_tready && !s_tvalid) uf_nxt = 1'b1;
                    if (fft_tlast && fft_tready) frame_nxt = frame_cnt + 16'd1;
                    if (dec_fac != active_dec) begin
                        if (dec_legal) pend_nxt = 1'b1;
                        else           df_nxt   = 1'b1;
                    end
                    if (!fft_tready) begin
                        stall_nxt = 1'b1;
`ifdef OSPFB_SEQ_AUTO_RECOVER_EN
                        state_nxt = IDLE;
                        if (restart_cnt != 8'hFF) restart_nxt = restart_cnt + 8'd1;
`else
                        state_nxt = HALT;
`endif
                    end else if (wrap && pend_nxt) begin
                        // New factor only takes effect at a frame boundary, via a full restart.
                        state_nxt = IDLE;
                    end
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (state_nxt != RUN) pend_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            active_dec    <= DF_W'(DEC_FAC_DEF);
            pend          <= 1'b0;
            frame_cnt     <= '0;
            err_underflow <= 1'b0;
            err_fft_stall <= 1'b0;
            err_dec_fac   <= 1'b0;
`ifdef OSPFB_SEQ_AUTO_RECOVER_EN
            restart_cnt   <= '0;
`endif
        end else begin
            state_q       <= state_nxt;
            active_dec    <= active_dec_nxt;
            pend          <= pend_nxt;
            frame_cnt     <= frame_nxt;
            err_underflow <= uf_nxt;
            err_fft_stall <= stall_nxt;
            err_dec_fac   <= df_nxt;
`ifdef OSPFB_SEQ_AUTO_RECOVER_EN
            restart_cnt   <= restart_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_ospfb_sequencer.sv
// Self-checking bench for ospfb_sequencer: directed scenarios plus randomized traffic
// compared cycle by cycle against a frame-level reference model.
module tb_ospfb_sequencer;
    import ospfb_seq_pkg::*;

    localparam int FFT_LEN = 32;
    localparam int DEC_DEF = 24;
    localparam int SRT     = 23;
    localparam int TLAST   = 31;

    localparam int M_IDLE = 0, M_CONFIG = 1, M_WAIT = 2, M_RUN = 3, M_HALT = 4;

    logic               clk = 1'b0;
    logic               rst, en, s_tvalid, cfg_tready, fft_tready;
    logic [DEC_W-1:0]   dec_fac;
    logic               s_tready, vin, fir_rst, cfg_tvalid, fft_tvalid, fft_tlast;
    logic [PHASE_W-1:0] phase;
    logic [7:0]         cfg_tdata;
    logic [15:0]        frame_cnt;
    logic               err_underflow, err_fft_stall, err_dec_fac;
    logic [2:0]         state;
`ifdef OSPFB_SEQ_AUTO_RECOVER_EN
    logic [7:0]         restart_cnt;
`endif

    ospfb_sequencer #(
        .FFT_LEN(FFT_LEN), .DEC_FAC_DEF(DEC_DEF), .SRT_PHA(SRT), .TLAST_PHA(TLAST),
        .CONF_WID(8), .CONF_DEF(0)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .dec_fac(dec_fac),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .vin(vin), .fir_rst(fir_rst),
        .phase(phase), .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready), .cfg_tdata(cfg_tdata),
        .fft_tvalid(fft_tvalid), .fft_tready(fft_tready), .fft_tlast(fft_tlast),
        .frame_cnt(frame_cnt), .err_underflow(err_underflow), .err_fft_stall(err_fft_stall),
        .err_dec_fac(err_dec_fac), .state(state)
`ifdef OSPFB_SEQ_AUTO_RECOVER_EN
        , .restart_cnt(restart_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_vin    = 0;
    int n_tlast  = 0;

    // Reference model state
    bit m_valid = 1'b0;
    int m_mode, m_phase, m_dec, m_frames, m_rc;
    bit m_pend, m_uf, m_st, m_df;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] exp_outs();
        bit run_act, srdy;
        run_act = (m_mode == M_RUN) && en;
        srdy    = run_act && (m_phase < m_dec);
        return {14'd0, 3'(m_mode), 5'(m_phase), srdy, srdy && s_tvalid, m_mode != M_RUN,
                m_mode == M_CONFIG, (m_mode == M_WAIT) || run_act,
                run_act && (m_phase == TLAST), m_uf, m_st, m_df};
    endfunction

    task automatic model_edge();
        bit legal;
        if (rst) begin
            m_mode = M_IDLE; m_phase = SRT; m_dec = DEC_DEF; m_pend = 0;
            m_frames = 0; m_uf = 0; m_st = 0; m_df = 0; m_rc = 0; m_valid = 1;
            return;
        end
        if (!m_valid) return;
        legal = (int'(dec_fac) >= 1) && (int'(dec_fac) <= FFT_LEN);
        case (m_mode)
            M_IDLE: if (en && s_tvalid) begin
                if (legal) m_dec = int'(dec_fac); else m_df = 1;
                m_mode = M_CONFIG;
            end
            M_CONFIG: if (cfg_tready) m_mode = M_WAIT;
            M_WAIT:   if (fft_tready) m_mode = M_RUN;
            M_RUN: if (en) begin
                if (m_phase < m_dec && !s_tvalid) m_uf = 1;
                if (m_phase == TLAST && fft_tready) m_frames = (m_frames + 1) % 65536;
                if (int'(dec_fac) != m_dec) begin
                    if (legal) m_pend = 1; else m_df = 1;
                end
                if (!fft_tready) begin
                    m_st = 1;
`ifdef OSPFB_SEQ_AUTO_RECOVER_EN
                    m_mode = M_IDLE;
                    if (m_rc < 255) m_rc++;
`else
                    m_mode = M_HALT;
`endif
                end else if (m_phase == FFT_LEN - 1 && m_pend) begin
                    m_mode = M_IDLE;
                end else begin
                    m_phase = (m_phase + 1) % FFT_LEN;
                end
                if (m_mode != M_RUN) begin
                    m_phase = SRT;
                    m_pend  = 0;
                end
            end
            default: ;
        endcase
    endtask

    // One clock: compare outputs at the falling edge, advance the model at the rising edge.
    task automatic tick();
        logic [31:0] act;
        @(negedge clk);
        if (m_valid) begin
            act = {14'd0, state, phase, s_tready, vin, fir_rst, cfg_tvalid, fft_tvalid,
                   fft_tlast, err_underflow, err_fft_stall, err_dec_fac};
            check("outs", act, exp_outs());
            check("frame_cnt", 32'(frame_cnt), 32'(m_frames));
`ifdef OSPFB_SEQ_AUTO_RECOVER_EN
            check("restart_cnt", 32'(restart_cnt), 32'(m_rc));
`endif
        end
        n_vin   += int'(vin);
        n_tlast += int'(fft_tlast);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wait_run();
        en = 1; s_tvalid = 1; cfg_tready = 1; fft_tready = 1;
        for (int i = 0; i < 20 && state != 3'(M_RUN); i++) tick();
        check("reach_run", 32'(state), 32'(M_RUN));
    endtask

    task automatic goto_phase(input int p, input string tag);
        for (int i = 0; i < 40 && int'(phase) != p; i++) tick();
        check(tag, 32'(phase), 32'(p));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, last_ph, p0;
        logic [15:0] f0;

        rst = 1; en = 0; s_tvalid = 0; cfg_tready = 0; fft_tready = 0; dec_fac = 6'd24;
        tick(); tick();
        check("rst_state", 32'(state), 32'(M_IDLE));
        check("rst_phase", 32'(phase), 32'(SRT));
        check("rst_fir_rst", 32'(fir_rst), 32'd1);
        check("rst_cfg_tdata", 32'(cfg_tdata), 32'd0);

        // Startup handshake sequence
        rst = 0; en = 1; s_tvalid = 1; cfg_tready = 1;
        tick(); tick();
        repeat (3) tick();
        fft_tready = 1;
        for (int i = 0; i < 8 && state != 3'(M_RUN); i++) tick();
        check("start_state", 32'(state), 32'(M_RUN));
        check("start_phase", 32'(phase), 32'(SRT));
        check("start_fir_rst", 32'(fir_rst), 32'd0);
        check("start_s_tready", 32'(s_tready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("late_phase_s_tready", 32'(s_tready), 32'd0);
        end

        // Steady state: 10 full frames
        n_vin = 0; n_tlast = 0; f0 = frame_cnt;
        repeat (320) tick();
        check("steady_vin", 32'(n_vin), 32'd240);
        check("steady_tlast", 32'(n_tlast), 32'd10);
        check("steady_frames", 32'(16'(frame_cnt - f0)), 32'd10);
        check("steady_errs", 32'({err_underflow, err_fft_stall, err_dec_fac}), 32'd0);

        // Underflow in an accept slot
        goto_phase(5, "uf_reach");
        s_tvalid = 0;
        #1;
        check("uf_vin", 32'(vin), 32'd0);
        check("uf_s_tready", 32'(s_tready), 32'd1);
        tick();
        s_tvalid = 1;
        check("uf_flag", 32'(err_underflow), 32'd1);
        check("uf_phase", 32'(phase), 32'd6);
        repeat (10) tick();
        check("uf_sticky", 32'(err_underflow), 32'd1);

        // Legal re-config mid-frame restarts after the last phase
        goto_phase(10, "recfg_reach");
        dec_fac = 6'd28;
        last_ph = -1;
        for (int i = 0; i < 40; i++) begin
            last_ph = int'(phase);
            tick();
            if (state == 3'(M_IDLE)) break;
        end
        check("recfg_idle", 32'(state), 32'(M_IDLE));
        check("recfg_last_phase", 32'(last_ph), 32'(FFT_LEN - 1));
        wait_run();
        goto_phase(0, "recfg_frame_start");
        cnt = 0;
        for (int i = 0; i < 32; i++) begin cnt += int'(s_tready); tick(); end
        check("recfg_accepts", 32'(cnt), 32'd28);

        // Illegal request: flagged, no restart, factor unchanged
        dec_fac = 6'd40;
        repeat (3) tick();
        check("illegal_flag", 32'(err_dec_fac), 32'd1);
        dec_fac = 6'd28;
        goto_phase(0, "illegal_frame_start");
        cnt = 0;
        for (int i = 0; i < 32; i++) begin cnt += int'(s_tready); tick(); end
        check("illegal_accepts", 32'(cnt), 32'd28);
        check("illegal_state", 32'(state), 32'(M_RUN));

        // Randomized traffic: gaps, underflows, factor changes, config back-pressure
        for (int i = 0; i < 1500; i++) begin
            en         = ($urandom_range(0, 99) < 88);
            s_tvalid   = ($urandom_range(0, 99) < 92);
            cfg_tready = 1'($urandom_range(0, 1));
            fft_tready = (m_mode == M_RUN) ? 1'b1 : 1'($urandom_range(0, 1));
            if ($urandom_range(0, 149) == 0) dec_fac = 6'($urandom_range(0, 63));
            tick();
        end

        // Enable gap, then reset mid-run
        rst = 1; tick(); tick(); rst = 0;
        dec_fac = 6'd24;
        wait_run();
        s_tvalid = 0; tick(); s_tvalid = 1;
        check("gap_uf_set", 32'(err_underflow), 32'd1);
        repeat (4) tick();
        p0 = int'(phase);
        en = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("gap_phase", 32'(phase), 32'(p0));
            check("gap_s_tready", 32'(s_tready), 32'd0);
            check("gap_fft_tvalid", 32'(fft_tvalid), 32'd0);
        end
        en = 1;
        goto_phase(12, "rst_mid_reach");
        rst = 1; tick(); rst = 0;
        check("rst_mid_state", 32'(state), 32'(M_IDLE));
        check("rst_mid_phase", 32'(phase), 32'(SRT));
        check("rst_mid_errs", 32'({err_underflow, err_fft_stall, err_dec_fac}), 32'd0);
        check("rst_mid_frames", 32'(frame_cnt), 32'd0);

        // FFT stall
        wait_run();
        repeat (5) tick();
        fft_tready = 0; tick(); fft_tready = 1;
        check("stall_flag", 32'(err_fft_stall), 32'd1);
`ifdef OSPFB_SEQ_AUTO_RECOVER_EN
        wait_run();
        check("stall_restart_cnt", 32'(restart_cnt), 32'd1);
        check("stall_sticky", 32'(err_fft_stall), 32'd1);
`else
        check("stall_state", 32'(state), 32'(M_HALT));
        check("stall_fir_rst", 32'(fir_rst), 32'd1);
        repeat (5) tick();
        check("halt_state", 32'(state), 32'(M_HALT));
        check("halt_outs", 32'({s_tready, fft_tvalid, cfg_tvalid}), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
